// File: rtl/axi_line_bridge.sv
// axi_line_bridge: cache line refill/write-back to 4-beat 32-bit AXI INCR bursts.
// Ports: clk/resetn; cache rd_*/ret_*/wr_*; AXI AR/R/AW/W/B master channels.
module axi_line_bridge (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_valid,
  output logic [31:0]  araddr,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [31:0]  awaddr,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_DATA, R_RET
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE, W_AW, W_DATA, W_RESP
  } wstate_e;

  rstate_e        r_q, r_d;
  wstate_e        w_q, w_d;
  logic [27:0]    rd_line_q, rd_line_d;
  logic [27:0]    wr_line_q, wr_line_d;
  logic [1:0]     rbeat_q, rbeat_d;
  logic [1:0]     wbeat_q, wbeat_d;
  logic [127:0]   ret_q, ret_d;
  logic [127:0]   wbuf_q, wbuf_d;
  logic           wr_valid_q, wr_valid_d;
  logic           rd_block;
  logic           unused_lsb;

  // Line offset bits carry no meaning for a full-line transfer.
  assign unused_lsb = ^{rd_addr[3:0], wr_addr[3:0]};

  // Hold off a refill of the line whose write-back is still in flight.
  assign rd_block = (w_q != W_IDLE) &&
                    (rd_addr[31:4] == wr_line_q);

  assign araddr   = {rd_line_q, 4'b0};
  assign awaddr   = {wr_line_q, 4'b0};
  assign ret_data = ret_q;
  assign wdata    = wbuf_q[{wbeat_q, 5'b0} +: 32];
  assign wr_valid = wr_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q        <= R_IDLE;
      w_q        <= W_IDLE;
      rd_line_q  <= '0;
      wr_line_q  <= '0;
      rbeat_q    <= '0;
      wbeat_q    <= '0;
      ret_q      <= '0;
      wbuf_q     <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      r_q        <= r_d;
      w_q        <= w_d;
      rd_line_q  <= rd_line_d;
      wr_line_q  <= wr_line_d;
      rbeat_q    <= rbeat_d;
      wbeat_q    <= wbeat_d;
      ret_q      <= ret_d;
      wbuf_q     <= wbuf_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  always_comb begin
    r_d       = r_q;
    rd_line_d = rd_line_q;
    rbeat_d   = rbeat_q;
    ret_d     = ret_q;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        rd_rdy = !rd_block;
        if (rd_req && !rd_block) begin
          rd_line_d = rd_addr[31:4];
          rbeat_d   = 2'd0;
          r_d       = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_d = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          ret_d[{rbeat_q, 5'b0} +: 32] = rdata;
          rbeat_d = rbeat_q + 2'd1;
          // rlast alone ends the burst, even if it comes early.
          if (rlast) r_d = R_RET;
        end
      end
      R_RET: begin
        ret_valid = 1'b1;
        r_d       = R_IDLE;
      end
      default: r_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_d        = w_q;
    wr_line_d  = wr_line_q;
    wbeat_d    = wbeat_q;
    wbuf_d     = wbuf_q;
    wr_valid_d = 1'b0;
    wr_rdy     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    unique case (w_q)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) begin
          wr_line_d = wr_addr[31:4];
          wbuf_d    = wr_data;
          wbeat_d   = 2'd0;
          w_d       = W_AW;
        end
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_d = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (wbeat_q == 2'd3);
        if (wready) begin
          wbeat_d = wbeat_q + 2'd1;
          if (wbeat_q == 2'd3) w_d = W_RESP;
        end
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          wr_valid_d = 1'b1;
          w_d        = W_IDLE;
        end
      end
      default: w_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_line_bridge.sv
// tb_axi_line_bridge: directed bench for axi_line_bridge.
// Drives the AXI slave side by hand, checks cycle-exact cache/AXI behaviour.
module tb_axi_line_bridge;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         wr_valid;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wexp [4];
  logic [31:0] rexp [4];

  always #5 clk = ~clk;

  axi_line_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Zero-wait R burst; entered on the first R_DATA cycle, leaves on the R_RET cycle.
  task automatic rd_beats(input string tag,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rdata  = d[i];
      rlast  = (i == 3);
      smp();
      chk({tag, "_rready"}, {rready, ret_valid}, 2'b10);
      nxt();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = '0;
  endtask

  initial begin
    {rd_req, wr_req, arready, rvalid, rlast} = '0;
    {awready, wready, bvalid} = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; rdata = '0;
    resetn = 1'b0;
    smp(); smp();
    chk("rst_strobes", {arvalid, rready, awvalid, wvalid,
        wlast, bready, ret_valid, wr_valid}, 8'h00);
    chk("rst_ret_data", ret_data, 128'h0);
    chk("rst_addr_data", {araddr, awaddr, wdata}, 96'h0);
    chk("rst_rdy", {rd_rdy, wr_rdy}, 2'b11);
    nxt(); resetn = 1'b1;

    // Zero-wait read
    rd_req = 1'b1; rd_addr = 32'h1FC0_0010;
    smp(); chk("t1_rd_rdy", rd_rdy, 1'b1);
    nxt(); rd_req = 1'b0; arready = 1'b1;
    smp(); chk("t1_arvalid", {arvalid, rready}, 2'b10);
    chk("t1_araddr", araddr, 32'h1FC0_0010);
    nxt(); arready = 1'b0;
    rd_beats("t1", 32'h11, 32'h22, 32'h33, 32'h44);
    smp(); chk("t1_ret_valid", ret_valid, 1'b1);
    chk("t1_ret_data", ret_data,
        128'h00000044_00000033_00000022_00000011);
    nxt(); smp();
    chk("t1_ret_pulse", {ret_valid, rd_rdy}, 2'b01);
    chk("t1_ret_stable", ret_data,
        128'h00000044_00000033_00000022_00000011);
    nxt();

    // Write-back with wready toggling
    wexp[0] = 32'hAAAA_AAAA; wexp[1] = 32'hBBBB_BBBB;
    wexp[2] = 32'hCCCC_CCCC; wexp[3] = 32'hDDDD_DDDD;
    wr_req = 1'b1; wr_addr = 32'h0000_1008;
    wr_data = {wexp[3], wexp[2], wexp[1], wexp[0]};
    smp(); chk("t2_wr_rdy", wr_rdy, 1'b1);
    nxt(); wr_req = 1'b0; wr_data = '0; awready = 1'b1;
    smp(); chk("t2_awvalid", {awvalid, wvalid}, 2'b10);
    chk("t2_awaddr", awaddr, 32'h0000_1000);
    nxt(); awready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wready = (i % 2 == 0);
      smp();
      chk("t2_wvalid", wvalid, 1'b1);
      chk("t2_wdata", wdata, wexp[(i + 1) / 2]);
      chk("t2_wlast", wlast, ((i + 1) / 2) == 3);
      nxt();
    end
    wready = 1'b0;
    smp(); chk("t2_bwait", {bready, wvalid, wr_valid}, 3'b100);
    nxt(); bvalid = 1'b1;
    smp(); chk("t2_bresp", {bready, wr_valid}, 2'b10);
    nxt(); bvalid = 1'b0;
    smp(); chk("t2_wr_valid", {wr_valid, wr_rdy, bready}, 3'b110);
    nxt(); smp(); chk("t2_wr_pulse", wr_valid, 1'b0);
    nxt();

    // Read with arready held off 5 cycles; offset bits ignored
    rd_req = 1'b1; rd_addr = 32'h0000_2347;
    smp(); chk("t3_rd_rdy", rd_rdy, 1'b1);
    nxt(); rd_req = 1'b0; rd_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t3_hold", {arvalid, rready, ret_valid}, 3'b100);
      chk("t3_araddr", araddr, 32'h0000_2340);
      nxt();
    end
    arready = 1'b1;
    smp(); chk("t3_ar_hs", arvalid, 1'b1);
    nxt(); arready = 1'b0; rd_addr = '0;
    rd_beats("t3", 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    smp(); chk("t3_ret_valid", ret_valid, 1'b1);
    chk("t3_ret_data", ret_data,
        128'h000000A4_000000A3_000000A2_000000A1);
    nxt();

    // Same-line ordering against a pending write-back
    wr_req = 1'b1; wr_addr = 32'h0000_0100;
    wr_data = 128'h44444444_33333333_22222222_11111111;
    smp(); chk("t4_wr_rdy", wr_rdy, 1'b1);
    nxt(); wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h0000_0200;
    smp(); chk("t4_other_line", {rd_rdy, awvalid}, 2'b11);
    nxt(); rd_req = 1'b0; arready = 1'b1;
    smp(); chk("t4_other_ar", araddr, 32'h0000_0200);
    nxt(); arready = 1'b0;
    rd_beats("t4a", 32'hB1, 32'hB2, 32'hB3, 32'hB4);
    smp(); chk("t4_other_ret", {ret_valid, awvalid}, 2'b11);
    chk("t4_other_data", ret_data,
        128'h000000B4_000000B3_000000B2_000000B1);
    nxt(); rd_req = 1'b1; rd_addr = 32'h0000_0104;
    smp(); chk("t4_block_aw", rd_rdy, 1'b0);
    nxt(); awready = 1'b1;
    smp(); chk("t4_block_awhs", rd_rdy, 1'b0);
    nxt(); awready = 1'b0; wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t4_block_w", {rd_rdy, arvalid}, 2'b00);
      chk("t4_wdata", wdata, 32'h1111_1111 * (i + 1));
      nxt();
    end
    wready = 1'b0; bvalid = 1'b1;
    smp(); chk("t4_block_b", {rd_rdy, bready}, 2'b01);
    nxt(); bvalid = 1'b0;
    smp(); chk("t4_release", {wr_valid, rd_rdy}, 2'b11);
    nxt(); rd_req = 1'b0; rd_addr = '0; arready = 1'b1;
    smp(); chk("t4_ar", arvalid, 1'b1);
    chk("t4_araddr", araddr, 32'h0000_0100);
    nxt(); arready = 1'b0;
    rd_beats("t4b", 32'hC1, 32'hC2, 32'hC3, 32'hC4);
    smp(); chk("t4_ret_valid", ret_valid, 1'b1);
    chk("t4_ret_data", ret_data,
        128'h000000C4_000000C3_000000C2_000000C1);
    nxt();

    // Concurrent read and write to different lines
    rexp[0] = 32'h0D0D_0001; rexp[1] = 32'h0D0D_0002;
    rexp[2] = 32'h0D0D_0003; rexp[3] = 32'h0D0D_0004;
    wexp[0] = 32'h5555_0000; wexp[1] = 32'h5555_1111;
    wexp[2] = 32'h5555_2222; wexp[3] = 32'h5555_3333;
    rd_req = 1'b1; rd_addr = 32'h0000_3000;
    wr_req = 1'b1; wr_addr = 32'h0000_4000;
    wr_data = {wexp[3], wexp[2], wexp[1], wexp[0]};
    smp(); chk("t5_both_rdy", {rd_rdy, wr_rdy}, 2'b11);
    nxt(); rd_req = 1'b0; wr_req = 1'b0;
    arready = 1'b1; awready = 1'b1;
    smp(); chk("t5_avalid", {arvalid, awvalid}, 2'b11);
    chk("t5_addrs", {araddr, awaddr}, {32'h0000_3000, 32'h0000_4000});
    nxt(); arready = 1'b0; awready = 1'b0; wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = rexp[i]; rlast = (i == 3);
      smp();
      chk("t5_rw_valid", {rready, wvalid}, 2'b11);
      chk("t5_wdata", {wlast, wdata}, {(i == 3), wexp[i]});
      nxt();
    end
    rvalid = 1'b0; rlast = 1'b0; wready = 1'b0; bvalid = 1'b1;
    smp(); chk("t5_ret_b", {ret_valid, bready, wr_valid}, 3'b110);
    chk("t5_ret_data", ret_data,
        {rexp[3], rexp[2], rexp[1], rexp[0]});
    nxt(); bvalid = 1'b0;
    smp(); chk("t5_wr_valid", {ret_valid, wr_valid}, 2'b01);
    nxt();
    smp(); chk("t5_idle", {ret_valid, wr_valid, rd_rdy, wr_rdy}, 4'b0011);
    nxt();

    // Reset during R_DATA beat 2, then a clean read
    rd_req = 1'b1; rd_addr = 32'h0000_5000;
    smp(); nxt(); rd_req = 1'b0; arready = 1'b1;
    smp(); nxt(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hE0E0_0001;
    smp(); nxt(); rdata = 32'hE0E0_0002;
    smp(); nxt(); rdata = 32'hE0E0_0003; resetn = 1'b0;
    smp(); chk("t6_rst", {rd_rdy, rready, ret_valid}, 3'b100);
    chk("t6_rst_data", ret_data, 128'h0);
    nxt(); resetn = 1'b1; rvalid = 1'b0; rdata = '0;
    rd_req = 1'b1; rd_addr = 32'h0000_6000;
    smp(); chk("t6_after", {rd_rdy, rready, ret_valid}, 3'b100);
    nxt(); rd_req = 1'b0; arready = 1'b1;
    smp(); chk("t6_araddr", {arvalid, araddr}, {1'b1, 32'h0000_6000});
    nxt(); arready = 1'b0;
    rd_beats("t6", 32'hF1, 32'hF2, 32'hF3, 32'hF4);
    smp(); chk("t6_ret_valid", ret_valid, 1'b1);
    chk("t6_ret_data", ret_data,
        128'h000000F4_000000F3_000000F2_000000F1);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
